// File: rtl/hfg_norm_scheduler.sv
// hfg_norm_scheduler: round-robin sharing of one fixed-latency normalization unit, with tag re-alignment and a credit-guarded result FIFO.
// Defining HFG_SCHED_STATS_EN adds per-requester saturating grant counters on oGrant_Count.
module hfg_norm_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_W        = 2,
  parameter int NORM_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   iClk,
  input  logic                   iReset_n,
  input  logic                   iEnable,
  input  logic [NUM_REQ-1:0]     iReq_Valid,
  input  logic [NUM_REQ*21-1:0]  iReq_Pre_Feature,
  output logic [NUM_REQ-1:0]     oReq_Ready,
  output logic [20:0]            oNorm_Pre_Feature,
  input  logic [31:0]            iNorm_Feature,
  output logic                   oRes_Valid,
  output logic [REQ_W-1:0]       oRes_Id,
  output logic [31:0]            oRes_Feature,
  input  logic                   iRes_Ready,
  output logic                   oBusy
`ifdef HFG_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  oGrant_Count
`endif
);
  localparam int STAGES = NORM_LATENCY + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int FW     = $clog2(STAGES + 1);
  localparam int SW     = CW + FW;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [REQ_W-1:0] ptr, gnt_id, cand;
  logic gnt, has_credit, push, pop, drained;
  logic [STAGES-1:0] tag_v;
  logic [REQ_W-1:0] tag_id [STAGES];
  logic [FW-1:0] in_flight;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [REQ_W+31:0] mem [FIFO_DEPTH];

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < STAGES; i++) in_flight = in_flight + FW'(tag_v[i]);
  end

  // Every issue still in the unit owns a FIFO slot, so the unit can never be stalled.
  assign has_credit = SW'(fifo_count) + SW'(in_flight) < SW'(FIFO_DEPTH);
  assign drained    = in_flight == '0 && fifo_count == '0;

  // Scan from the farthest candidate back to ptr so the closest valid one wins.
  always_comb begin
    gnt    = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = REQ_W'((int'(ptr) + i) % NUM_REQ);
      if (iReq_Valid[cand]) begin
        gnt    = 1'b1;
        gnt_id = cand;
      end
    end
    gnt = gnt && state == RUN && has_credit;
  end

  assign oReq_Ready = gnt ? NUM_REQ'(1) << gnt_id : '0;

  always_comb begin
    state_nx = state;
    if (iEnable) state_nx = RUN;
    else if (state == RUN || (state == DRAIN && !drained)) state_nx = DRAIN;
    else state_nx = IDLE;
  end

  assign push         = tag_v[STAGES-1];
  assign oRes_Valid   = fifo_count != '0;
  assign pop          = oRes_Valid && iRes_Ready;
  assign oRes_Id      = oRes_Valid ? mem[rd_ptr][REQ_W+31:32] : '0;
  assign oRes_Feature = oRes_Valid ? mem[rd_ptr][31:0] : '0;
  assign oBusy        = state != IDLE;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state             <= IDLE;
      ptr               <= '0;
      oNorm_Pre_Feature <= '0;
      tag_v             <= '0;
      for (int i = 0; i < STAGES; i++) tag_id[i] <= '0;
      fifo_count        <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
    end else begin
      state     <= state_nx;
      tag_v     <= {tag_v[STAGES-2:0], gnt};
      tag_id[0] <= gnt_id;
      for (int i = 1; i < STAGES; i++) tag_id[i] <= tag_id[i-1];
      if (gnt) begin
        ptr               <= int'(gnt_id) == NUM_REQ - 1 ? '0 : gnt_id + 1'b1;
        oNorm_Pre_Feature <= iReq_Pre_Feature[int'(gnt_id)*21 +: 21];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // The last tag stage lines up with the unit output, so its id travels with the result.
  always_ff @(posedge iClk) begin
    if (push) mem[wr_ptr] <= {tag_id[STAGES-1], iNorm_Feature};
  end

  assert property (@(posedge iClk) disable iff (!iReset_n)
    !(push && !pop && fifo_count == CW'(FIFO_DEPTH)));

`ifdef HFG_SCHED_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (gnt && grant_cnt[gnt_id] != 16'hFFFF) begin
      grant_cnt[gnt_id] <= grant_cnt[gnt_id] + 16'd1;
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
    assign oGrant_Count[16*k +: 16] = grant_cnt[k];
  end
`endif
endmodule

// File: tb/tb_hfg_norm_scheduler.sv
// tb_hfg_norm_scheduler: directed and randomized checks of hfg_norm_scheduler against a queue-based model.
// The normalization unit is modelled here as |x|*11664>>6 with sign restored, two cycles after sampling.
module tb_hfg_norm_scheduler;
  localparam int N = 4;
  logic        iClk = 0, iReset_n = 0, iEnable = 0;
  logic [3:0]  iReq_Valid = 0;
  logic [83:0] iReq_Pre_Feature = 0;
  logic [3:0]  oReq_Ready;
  logic [20:0] oNorm_Pre_Feature;
  logic [31:0] iNorm_Feature;
  logic        oRes_Valid;
  logic [1:0]  oRes_Id;
  logic [31:0] oRes_Feature;
  logic        iRes_Ready = 1;
  logic        oBusy;
`ifdef HFG_SCHED_STATS_EN
  logic [63:0] oGrant_Count;
`endif
  int ntests = 0, nfail = 0;

  hfg_norm_scheduler dut (
    .iClk(iClk), .iReset_n(iReset_n), .iEnable(iEnable),
    .iReq_Valid(iReq_Valid), .iReq_Pre_Feature(iReq_Pre_Feature), .oReq_Ready(oReq_Ready),
    .oNorm_Pre_Feature(oNorm_Pre_Feature), .iNorm_Feature(iNorm_Feature),
    .oRes_Valid(oRes_Valid), .oRes_Id(oRes_Id), .oRes_Feature(oRes_Feature),
    .iRes_Ready(iRes_Ready), .oBusy(oBusy)
`ifdef HFG_SCHED_STATS_EN
    , .oGrant_Count(oGrant_Count)
`endif
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] norm(input logic [20:0] x);
    longint v = longint'($signed(x));
    longint m = v < 0 ? -v : v;
    longint r = (m * 11664) / 64;
    return v < 0 ? 32'(-r) : 32'(r);
  endfunction

  logic [31:0] u1 = 0, u2 = 0;
  always @(posedge iClk) begin
    u1 <= norm(oNorm_Pre_Feature);
    u2 <= u1;
  end
  assign iNorm_Feature = u2;

  typedef struct {int age; int id; logic [31:0] feat;} item_t;
  item_t m_fly[$];
  item_t m_fifo[$];
  item_t m_it;
  int m_state = 0, m_ptr = 0, m_g;
  bit m_drained;

  function automatic int m_grant();
    if (m_state != 1 || N - m_fifo.size() - m_fly.size() <= 0) return -1;
    for (int i = 0; i < N; i++) if (iReq_Valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // States: 0 idle, 1 run, 2 drain. Issues age one per edge and land in the FIFO on the third edge.
  always @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      m_fly.delete();
      m_fifo.delete();
      m_state = 0;
      m_ptr = 0;
    end else begin
      m_g = m_grant();
      m_drained = m_fly.size() == 0 && m_fifo.size() == 0;
      if (m_fifo.size() > 0 && iRes_Ready) void'(m_fifo.pop_front());
      while (m_fly.size() > 0 && m_fly[0].age == 2) m_fifo.push_back(m_fly.pop_front());
      foreach (m_fly[i]) m_fly[i].age++;
      if (m_g >= 0) begin
        m_it.age = 0;
        m_it.id = m_g;
        m_it.feat = norm(iReq_Pre_Feature[m_g*21 +: 21]);
        m_fly.push_back(m_it);
        m_ptr = (m_g + 1) % N;
      end
      case (m_state)
        0: if (iEnable) m_state = 1;
        1: if (!iEnable) m_state = 2;
        default: if (iEnable) m_state = 1; else if (m_drained) m_state = 0;
      endcase
    end
  end

  task automatic settle();
    iReq_Valid = 0;
    iRes_Ready = 1;
    iEnable = 1;
    repeat (12) @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iReset_n = 0;
    repeat (2) @(posedge iClk);
    #1;
    ntests++;
    if ({oReq_Ready, oNorm_Pre_Feature, oRes_Valid, oRes_Id, oRes_Feature, oBusy} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: got ready=%h pre=%h valid=%b id=%0d feat=%h busy=%b, want all 0",
               oReq_Ready, oNorm_Pre_Feature, oRes_Valid, oRes_Id, oRes_Feature, oBusy);
    end
    @(negedge iClk);
    iReset_n = 1;
    repeat (2) @(posedge iClk);
    #1;
    ntests++;
    if (oBusy !== 1'b0) begin
      nfail++;
      $display("FAIL idle_without_enable: busy got %b want 0", oBusy);
    end
  endtask

  task automatic test_single_issue(input int k, input logic [20:0] x, input logic [31:0] want);
    bit got = 0;
    settle();
    iReq_Pre_Feature = 84'({$urandom, $urandom, $urandom});
    iReq_Pre_Feature[k*21 +: 21] = x;
    iReq_Valid = 4'(1) << k;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge iClk);
      if (oReq_Ready === 4'(1) << k) got = 1;
      else @(posedge iClk);
    end
    ntests++;
    if (!got) begin
      nfail++;
      $display("FAIL single_grant_%0d: ready got %h want %h", k, oReq_Ready, 4'(1) << k);
    end
    @(posedge iClk);
    #1;
    iReq_Valid = 0;
    repeat (2) @(posedge iClk);
    #1;
    ntests++;
    if (oRes_Valid !== 1'b0) begin
      nfail++;
      $display("FAIL single_early_%0d: valid got %b want 0 two edges after grant", k, oRes_Valid);
    end
    @(posedge iClk);
    #1;
    ntests++;
    if ({oRes_Valid, oRes_Id, oRes_Feature} !== {1'b1, 2'(k), want}) begin
      nfail++;
      $display("FAIL single_result_%0d: got valid=%b id=%0d feat=%h want valid=1 id=%0d feat=%h",
               k, oRes_Valid, oRes_Id, oRes_Feature, k, want);
    end
  endtask

  task automatic test_all_valid(input int first);
    item_t q[$];
    item_t it;
    int nxt = first, ng = 0, gi;
    settle();
    iReq_Pre_Feature = 84'({$urandom, $urandom, $urandom});
    iReq_Valid = 4'hF;
    for (int c = 0; c < 80; c++) begin
      if (c == 50) iReq_Valid = 0;
      @(negedge iClk);
      gi = -1;
      if (oReq_Ready != 0) begin
        ntests++;
        if (oReq_Ready !== 4'(1) << nxt) begin
          nfail++;
          $display("FAIL rr_order: ready got %h want %h", oReq_Ready, 4'(1) << nxt);
        end
        gi = onehot_idx(oReq_Ready);
        it.id = gi;
        it.feat = norm(iReq_Pre_Feature[gi*21 +: 21]);
        q.push_back(it);
        nxt = (gi + 1) % N;
        ng++;
      end
      if (oRes_Valid) begin
        ntests++;
        if (q.size() == 0) begin
          nfail++;
          $display("FAIL rr_result: got id=%0d feat=%h want no result", oRes_Id, oRes_Feature);
        end else begin
          if ({oRes_Id, oRes_Feature} !== {2'(q[0].id), q[0].feat}) begin
            nfail++;
            $display("FAIL rr_result: got id=%0d feat=%h want id=%0d feat=%h",
                     oRes_Id, oRes_Feature, q[0].id, q[0].feat);
          end
          void'(q.pop_front());
        end
      end
      @(posedge iClk);
      #1;
      if (gi >= 0) iReq_Pre_Feature[gi*21 +: 21] = 21'($urandom);
    end
    ntests++;
    if (ng < 12 || q.size() != 0) begin
      nfail++;
      $display("FAIL rr_totals: grants got %0d want >=12, leftover got %0d want 0", ng, q.size());
    end
  endtask

  task automatic test_backpressure();
    item_t q[$];
    item_t it;
    int ng = 0, nres = 0;
    settle();
    iRes_Ready = 0;
    iReq_Pre_Feature = 84'({$urandom, $urandom, $urandom});
    iReq_Valid = 4'b0010;
    for (int c = 0; c < 30; c++) begin
      @(negedge iClk);
      if (oReq_Ready[1]) begin
        it.id = 1;
        it.feat = norm(iReq_Pre_Feature[21 +: 21]);
        q.push_back(it);
        ng++;
      end
      @(posedge iClk);
      #1;
      iReq_Pre_Feature[21 +: 21] = 21'($urandom);
    end
    @(negedge iClk);
    ntests++;
    if (ng != 4 || oReq_Ready !== 4'b0) begin
      nfail++;
      $display("FAIL bp_grants: got %0d grants ready=%h want 4 grants ready=0", ng, oReq_Ready);
    end
    ntests++;
    if (oRes_Valid !== 1'b1 || oRes_Id !== 2'd1) begin
      nfail++;
      $display("FAIL bp_full_head: got valid=%b id=%0d want valid=1 id=1", oRes_Valid, oRes_Id);
    end
    @(posedge iClk);
    #1;
    iReq_Valid = 0;
    iRes_Ready = 1;
    for (int c = 0; c < 15; c++) begin
      @(negedge iClk);
      if (oRes_Valid) begin
        nres++;
        ntests++;
        if (q.size() == 0 || {oRes_Id, oRes_Feature} !== {2'(q[0].id), q[0].feat}) begin
          nfail++;
          $display("FAIL bp_result: got id=%0d feat=%h want %0s", oRes_Id, oRes_Feature,
                   q.size() == 0 ? "no result" : $sformatf("id=%0d feat=%h", q[0].id, q[0].feat));
        end
        if (q.size() > 0) void'(q.pop_front());
      end
    end
    ntests++;
    if (nres != 4) begin
      nfail++;
      $display("FAIL bp_count: results got %0d want 4", nres);
    end
  endtask

  task automatic test_drain();
    item_t q[$];
    item_t it;
    int ng = 0, nres = 0, extra = 0, gi;
    bit idle_seen = 0;
    settle();
    iReq_Pre_Feature = 84'({$urandom, $urandom, $urandom});
    iReq_Valid = 4'hF;
    for (int c = 0; c < 40 && ng < 3; c++) begin
      @(negedge iClk);
      if (oReq_Ready != 0) begin
        gi = onehot_idx(oReq_Ready);
        it.id = gi;
        it.feat = norm(iReq_Pre_Feature[gi*21 +: 21]);
        q.push_back(it);
        ng++;
        if (ng == 3) iEnable = 0;
      end
      @(posedge iClk);
      #1;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge iClk);
      if (c == 0) begin
        ntests++;
        if (oBusy !== 1'b1) begin
          nfail++;
          $display("FAIL drain_busy: busy got %b want 1 in drain", oBusy);
        end
      end
      if (oReq_Ready != 0) extra++;
      if (oRes_Valid) begin
        nres++;
        ntests++;
        if (q.size() == 0 || {oRes_Id, oRes_Feature} !== {2'(q[0].id), q[0].feat}) begin
          nfail++;
          $display("FAIL drain_result: got id=%0d feat=%h want %0s", oRes_Id, oRes_Feature,
                   q.size() == 0 ? "no result" : $sformatf("id=%0d feat=%h", q[0].id, q[0].feat));
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      if (!oBusy && !idle_seen) begin
        idle_seen = 1;
        ntests++;
        if (nres != 3) begin
          nfail++;
          $display("FAIL drain_idle_early: results at idle got %0d want 3", nres);
        end
      end
      @(posedge iClk);
      #1;
    end
    iReq_Valid = 0;
    ntests++;
    if (ng != 3 || extra != 0 || nres != 3 || !idle_seen) begin
      nfail++;
      $display("FAIL drain_totals: grants=%0d extra=%0d results=%0d idle=%b want 3 0 3 1",
               ng, extra, nres, idle_seen);
    end
  endtask

  task automatic test_reset_midflight();
    int ng = 0, nres = 0;
    settle();
    iReq_Pre_Feature = 84'({$urandom, $urandom, $urandom});
    iReq_Valid = 4'b0001;
    for (int c = 0; c < 20 && ng < 2; c++) begin
      @(negedge iClk);
      if (oReq_Ready[0]) ng++;
      @(posedge iClk);
      #1;
    end
    iReq_Valid = 0;
    #1;
    iReset_n = 0;
    #1;
    ntests++;
    if (ng != 2 || {oReq_Ready, oNorm_Pre_Feature, oRes_Valid, oRes_Id, oRes_Feature, oBusy} !== '0) begin
      nfail++;
      $display("FAIL async_reset: grants=%0d ready=%h pre=%h valid=%b busy=%b want 2 grants and all 0",
               ng, oReq_Ready, oNorm_Pre_Feature, oRes_Valid, oBusy);
    end
    iEnable = 0;
    @(negedge iClk);
    iReset_n = 1;
    repeat (10) begin
      @(negedge iClk);
      if (oRes_Valid) nres++;
    end
    ntests++;
    if (nres != 0 || oBusy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_discard: results got %0d busy=%b want 0 results busy=0", nres, oBusy);
    end
    @(posedge iClk);
    #1;
  endtask

  task automatic test_random();
    int g;
    logic [3:0] want;
    for (int c = 0; c < 600; c++) begin
      iReq_Valid = 4'($urandom);
      iReq_Pre_Feature = 84'({$urandom, $urandom, $urandom});
      iRes_Ready = $urandom_range(0, 3) != 0;
      iEnable = $urandom_range(0, 11) != 0;
      @(negedge iClk);
      g = m_grant();
      want = g < 0 ? 4'b0 : 4'(1) << g;
      ntests++;
      if (oReq_Ready !== want) begin
        nfail++;
        $display("FAIL rand_ready@%0d: got %h want %h", c, oReq_Ready, want);
      end
      ntests++;
      if (oRes_Valid !== (m_fifo.size() != 0)) begin
        nfail++;
        $display("FAIL rand_valid@%0d: got %b want %b", c, oRes_Valid, m_fifo.size() != 0);
      end
      if (m_fifo.size() != 0) begin
        ntests++;
        if ({oRes_Id, oRes_Feature} !== {2'(m_fifo[0].id), m_fifo[0].feat}) begin
          nfail++;
          $display("FAIL rand_head@%0d: got id=%0d feat=%h want id=%0d feat=%h",
                   c, oRes_Id, oRes_Feature, m_fifo[0].id, m_fifo[0].feat);
        end
      end
      ntests++;
      if (oBusy !== (m_state != 0)) begin
        nfail++;
        $display("FAIL rand_busy@%0d: got %b want %b", c, oBusy, m_state != 0);
      end
      @(posedge iClk);
      #1;
    end
    iEnable = 0;
    iReq_Valid = 0;
    iRes_Ready = 1;
    repeat (20) @(posedge iClk);
    #1;
    ntests++;
    if (oBusy !== 1'b0 || oRes_Valid !== 1'b0) begin
      nfail++;
      $display("FAIL rand_final_idle: busy=%b valid=%b want 0 0", oBusy, oRes_Valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_issue(0, 21'd1, 32'd182);
    test_single_issue(2, 21'h1FFF9C, 32'hFFFFB8CF);
    test_all_valid(3);
    test_backpressure();
    test_drain();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
